pla_root_iter: RTL

//  Sequential, parametrised integer square-root unit; successor to the 8-in/5-out combinational root PLA.

---
 rtl/pla_root_iter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pla_root_iter.sv
// Iterative integer square root, one root bit per clock; result after WIDTH/2 edges.
// Accepts only in IDLE; the result is held with out_valid until out_ready, then returns to IDLE.
module pla_root_iter #(
  parameter int WIDTH      = 8,
  parameter int ROUND_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
  output logic [WIDTH/2:0]   out_rem,
  output logic               out_sat
);

  localparam int RW   = WIDTH / 2;
  localparam int ITER = RW;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("pla_root_iter: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [WIDTH-1:0] x_q;
  logic [RW-1:0]   root_q;
  logic [RW+1:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [RW-1:0]   out_root_q;
  logic [RW:0]     out_rem_q;
  logic            out_sat_q;

  logic [RW+1:0]   rem_sh;
  logic [RW+2:0]   trial;
  logic            ge;
  logic [RW:0]     root_ext;
  logic [RW-1:0]   root_d;
  logic [RW+1:0]   rem_d;
  logic [RW:0]     root_inc;
  logic            root_ovf;
  logic            round_up;
  logic [RW-1:0]   root_rnd;

  // The partial remainder before the last step is below 2^RW, so only its low RW bits are shifted.
  always_comb begin
    rem_sh   = {rem_q[RW-1:0], x_q[WIDTH-1 -: 2]};
    trial    = {1'b0, rem_sh} - {1'b0, root_q, 2'b01};
    ge       = ~trial[RW+2];
    rem_d    = ge ? trial[RW+1:0] : rem_sh;
    root_ext = {root_q, ge};
    root_d   = root_ext[RW-1:0];
    root_inc = {1'b0, root_d} + {{RW{1'b0}}, 1'b1};
    root_ovf = root_inc[RW];
    round_up = (ROUND_MODE != 0) && (rem_d[RW:0] > {1'b0, root_d});
    root_rnd = root_ovf ? {RW{1'b1}} : root_inc[RW-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{rem_q[RW+1:RW], root_ext[RW], rem_d[RW+1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= in_x;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= CNT_INIT;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          x_q    <= x_q << 2;
          root_q <= root_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            out_root_q  <= round_up ? root_rnd : root_d;
            out_rem_q   <= rem_d[RW:0];
            out_sat_q   <= round_up && root_ovf;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_sat   = out_sat_q;

endmodule
